// File: rtl/sobel_frame_writer_pkg.sv
// Shared Sobel path definitions: pixel width,
// default frame geometry and writer FSM states.
package sobel_pkg;

  localparam int BYTE_SIZE = 8;
  localparam int IMAGE_WIDTH_E = 9;
  localparam int IMAGE_HIGHT_E = 9;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    WRITE    = 2'd2,
    DONE     = 2'd3
  } state_t;

endpackage

// File: rtl/sobel_frame_writer_if.sv
// Pixel stream with valid/ready handshake plus
// start-of-frame and end-of-line markers.
interface sobel_stream_if
  import sobel_pkg::*;
#(
  parameter int BYTE_SIZE = sobel_pkg::BYTE_SIZE
);

  logic                 valid;
  logic                 ready;
  logic [BYTE_SIZE-1:0] data;
  logic                 sof;
  logic                 eol;

  modport master (
    output valid, data, sof, eol,
    input  ready
  );

  modport slave (
    input  valid, data, sof, eol,
    output ready
  );

endinterface

// File: rtl/sobel_frame_writer_pos.sv
// Row/column tracker for the frame writer with
// end-of-line resync and frame restart.
module pixel_pos_counter
  import sobel_pkg::*;
#(
  parameter int W_E = sobel_pkg::IMAGE_WIDTH_E,
  parameter int H_E = sobel_pkg::IMAGE_HIGHT_E
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           restart,
  input  logic           inc,
  input  logic           eol,
  output logic [W_E-1:0] col,
  output logic [H_E-1:0] row,
  output logic           last_col,
  output logic           last_pixel
);

  localparam int WIDTH = 2 ** W_E;
  localparam int HIGHT = 2 ** H_E;

  logic last_row;

  assign last_col   = (col == W_E'(WIDTH - 1));
  assign last_row   = (row == H_E'(HIGHT - 1));
  assign last_pixel = last_row & (last_col | eol);

  // Step position; a line ends by position or by an early eol.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (restart) begin
      col <= W_E'(1);
      row <= '0;
    end else if (inc) begin
      if (last_col | eol) begin
        col <= '0;
        if (!last_row)
          row <= row + H_E'(1);
      end else begin
        col <= col + W_E'(1);
      end
    end
  end

endmodule

// File: rtl/sobel_frame_writer.sv
// Sobel output sink: writes the framed pixel stream
// into the frame buffer and flags framing errors.
module sobel_frame_writer
  import sobel_pkg::*;
#(
  parameter int IMAGE_WIDTH_E = sobel_pkg::IMAGE_WIDTH_E,
  parameter int IMAGE_HIGHT_E = sobel_pkg::IMAGE_HIGHT_E,
  parameter int BYTE_SIZE     = sobel_pkg::BYTE_SIZE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  sobel_stream_if.slave s,
  output logic        mem_we,
  output logic [IMAGE_WIDTH_E+IMAGE_HIGHT_E-1:0] mem_addr,
  output logic [BYTE_SIZE-1:0] mem_wdata,
  output logic        busy,
  output logic        frame_done,
  output logic        err_sync
);

  localparam int AW = IMAGE_WIDTH_E + IMAGE_HIGHT_E;

  state_t state_q, state_d;

  logic                     ready;
  logic                     xfer;
  logic                     clear, restart, inc, wr;
  logic                     err_set, err_clr;
  logic [IMAGE_WIDTH_E-1:0] col;
  logic [IMAGE_HIGHT_E-1:0] row;
  logic                     last_col, last_pixel;

  assign ready      = (state_q == WAIT_SOF) |
                      (state_q == WRITE);
  assign s.ready    = ready;
  assign busy       = ready;
  assign frame_done = (state_q == DONE);
  assign xfer       = s.valid & ready;

  pixel_pos_counter #(
    .W_E (IMAGE_WIDTH_E),
    .H_E (IMAGE_HIGHT_E)
  ) u_pos (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .restart    (restart),
    .inc        (inc),
    .eol        (s.eol),
    .col        (col),
    .row        (row),
    .last_col   (last_col),
    .last_pixel (last_pixel)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state, counter controls and error set/clear.
  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    restart = 1'b0;
    inc     = 1'b0;
    wr      = 1'b0;
    err_set = 1'b0;
    err_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT_SOF;
          clear   = 1'b1;
          err_clr = 1'b1;
        end
      end
      WAIT_SOF: begin
        if (xfer && s.sof) begin
          state_d = WRITE;
          restart = 1'b1;
          wr      = 1'b1;
        end
      end
      WRITE: begin
        if (xfer) begin
          wr = 1'b1;
          if (s.sof) begin
            restart = 1'b1;
            err_set = 1'b1;
          end else begin
            inc = 1'b1;
            if (s.eol != last_col)
              err_set = 1'b1;
            if (last_pixel)
              state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register the write one cycle after its transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= wr;
      if (wr) begin
        mem_addr  <= restart ? AW'(0) : {row, col};
        mem_wdata <= s.data;
      end
    end
  end

  // Sticky framing error, cleared when a frame is armed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        err_sync <= 1'b0;
    else if (err_clr) err_sync <= 1'b0;
    else if (err_set) err_sync <= 1'b1;
  end

endmodule

// File: tb/tb_sobel_frame_writer.sv
// Directed bench for sobel_frame_writer on a 4x4
// frame with a behavioural frame-buffer RAM.
module tb_sobel_frame_writer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       busy, frame_done, err_sync;

  sobel_stream_if #(.BYTE_SIZE(8)) s_if ();

  sobel_frame_writer #(
    .IMAGE_WIDTH_E (2),
    .IMAGE_HIGHT_E (2),
    .BYTE_SIZE     (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .s          (s_if),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .frame_done (frame_done),
    .err_sync   (err_sync)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int we_count = 0;
  int done_count = 0;
  int we_viol = 0;
  logic       xfer_q;
  logic       ram_clr = 1'b0;
  logic [7:0] ram [16];
  logic [7:0] exp_img [16];

  // Frame-buffer model and event counters.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_clr)
      for (int i = 0; i < 16; i++) ram[i] <= 8'hFF;
    else if (mem_we)
      ram[mem_addr] <= mem_wdata;
    if (mem_we) we_count <= we_count + 1;
    if (frame_done) done_count <= done_count + 1;
  end

  // Track transfers; mem_we must follow exactly one cycle later.
  always @(posedge clk or posedge reset) begin
    if (reset) xfer_q <= 1'b0;
    else       xfer_q <= s_if.valid & s_if.ready;
  end

  always @(negedge clk) begin
    if (!reset && mem_we !== xfer_q) we_viol <= we_viol + 1;
  end

  task automatic clear_ram();
    ram_clr = 1'b1;
    @(posedge clk); #1;
    ram_clr = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d,
                      input logic sof,
                      input logic eol);
    int   n;
    logic acc;
    s_if.valid = 1'b1;
    s_if.data  = d;
    s_if.sof   = sof;
    s_if.eol   = eol;
    n = 0;
    do begin
      acc = s_if.ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 20);
    if (!acc) begin
      checks++;
      $display("FAIL send_timeout data=%0h no ready in 20 cycles", d);
    end
    s_if.valid = 1'b0;
    s_if.sof   = 1'b0;
    s_if.eol   = 1'b0;
  endtask

  task automatic send_frame(input bit gap);
    for (int i = 0; i < 16; i++) begin
      send(8'(i), i == 0, (i % 4) == 3);
      if (gap && i < 15) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic set_exp_ramp();
    for (int i = 0; i < 16; i++) exp_img[i] = 8'(i);
  endtask

  task automatic check_img(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (ram[i] !== exp_img[i]) bad++;
    checks++;
    if (bad !== 0)
      $display("FAIL %s: %0d bad entries, required 0", name, bad);
    else passes++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    s_if.valid = 1'b0;
    s_if.data  = '0;
    s_if.sof   = 1'b0;
    s_if.eol   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({s_if.ready, mem_we, mem_addr, mem_wdata, busy,
         frame_done, err_sync} !== 17'd0)
      $display("FAIL reset_outputs: got %b, required 0",
               {s_if.ready, mem_we, mem_addr, mem_wdata, busy,
                frame_done, err_sync});
    else passes++;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({s_if.ready, busy} !== 2'b00)
      $display("FAIL idle_after_reset: got %b, required 00",
               {s_if.ready, busy});
    else passes++;
  endtask

  task automatic test_clean_frame();
    int w0, d0, v0, t0;
    clear_ram();
    w0 = we_count; d0 = done_count; v0 = we_viol;
    start = 1'b1;
    checks++;
    if (s_if.ready !== 1'b0)
      $display("FAIL ready_before_start: got %b, required 0", s_if.ready);
    else passes++;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (s_if.ready !== 1'b1 || busy !== 1'b1)
      $display("FAIL ready_after_start: got %b%b, required 11",
               s_if.ready, busy);
    else passes++;
    t0 = cyc;
    send_frame(1'b0);
    checks++;
    if (cyc - t0 !== 16)
      $display("FAIL throughput: %0d cycles, required 16", cyc - t0);
    else passes++;
    checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0)
      $display("FAIL clean_done: done=%b busy=%b, required 1 0",
               frame_done, busy);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (frame_done !== 1'b0 || s_if.ready !== 1'b0)
      $display("FAIL clean_after_done: done=%b ready=%b, required 0 0",
               frame_done, s_if.ready);
    else passes++;
    set_exp_ramp();
    check_img("clean_ram");
    checks++;
    if (we_count - w0 !== 16 || done_count - d0 !== 1)
      $display("FAIL clean_counts: writes=%0d dones=%0d, required 16 1",
               we_count - w0, done_count - d0);
    else passes++;
    checks++;
    if (err_sync !== 1'b0 || we_viol - v0 !== 0)
      $display("FAIL clean_err: err=%b we_viol=%0d, required 0 0",
               err_sync, we_viol - v0);
    else passes++;
  endtask

  task automatic test_backpressure();
    int w0, d0, v0;
    clear_ram();
    w0 = we_count; d0 = done_count; v0 = we_viol;
    do_start();
    send_frame(1'b1);
    checks++;
    if (frame_done !== 1'b1)
      $display("FAIL bp_done: got %b, required 1", frame_done);
    else passes++;
    @(posedge clk); #1;
    set_exp_ramp();
    check_img("bp_ram");
    checks++;
    if (we_count - w0 !== 16 || done_count - d0 !== 1 ||
        we_viol - v0 !== 0)
      $display("FAIL bp_counts: w=%0d d=%0d viol=%0d, required 16 1 0",
               we_count - w0, done_count - d0, we_viol - v0);
    else passes++;
  endtask

  task automatic test_pre_sof();
    int w0;
    clear_ram();
    w0 = we_count;
    do_start();
    for (int i = 0; i < 3; i++) send(8'hF1 + 8'(i), 1'b0, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (we_count - w0 !== 0 || busy !== 1'b1)
      $display("FAIL garbage_writes: w=%0d busy=%b, required 0 1",
               we_count - w0, busy);
    else passes++;
    send_frame(1'b0);
    checks++;
    if (frame_done !== 1'b1)
      $display("FAIL presof_done: got %b, required 1", frame_done);
    else passes++;
    @(posedge clk); #1;
    set_exp_ramp();
    check_img("presof_ram");
    checks++;
    if (we_count - w0 !== 16 || err_sync !== 1'b0)
      $display("FAIL presof_counts: w=%0d err=%b, required 16 0",
               we_count - w0, err_sync);
    else passes++;
  endtask

  task automatic test_early_eol();
    int w0, d0;
    clear_ram();
    w0 = we_count; d0 = done_count;
    do_start();
    for (int i = 0; i < 6; i++)
      send(8'h20 + 8'(i), i == 0, i == 3 || i == 5);
    checks++;
    if (err_sync !== 1'b1)
      $display("FAIL eol_err: got %b, required 1", err_sync);
    else passes++;
    for (int i = 6; i < 14; i++)
      send(8'h20 + 8'(i), 1'b0, ((8 + i - 6) % 4) == 3);
    checks++;
    if (frame_done !== 1'b1)
      $display("FAIL eol_done: got %b, required 1", frame_done);
    else passes++;
    @(posedge clk); #1;
    for (int a = 0; a < 16; a++) exp_img[a] = 8'hFF;
    for (int a = 0; a < 6; a++) exp_img[a] = 8'h20 + 8'(a);
    for (int a = 8; a < 16; a++) exp_img[a] = 8'h26 + 8'(a - 8);
    checks++;
    if (ram[8] !== 8'h26)
      $display("FAIL eol_resync_addr8: got %0h, required 26", ram[8]);
    else passes++;
    check_img("eol_ram");
    checks++;
    if (we_count - w0 !== 14 || done_count - d0 !== 1)
      $display("FAIL eol_counts: w=%0d d=%0d, required 14 1",
               we_count - w0, done_count - d0);
    else passes++;
  endtask

  task automatic test_mid_sof();
    int d0;
    clear_ram();
    d0 = done_count;
    do_start();
    for (int i = 0; i < 5; i++)
      send(8'h30 + 8'(i), i == 0, i == 3);
    checks++;
    if (err_sync !== 1'b0)
      $display("FAIL midsof_pre_err: got %b, required 0", err_sync);
    else passes++;
    send(8'hAA, 1'b1, 1'b0);
    checks++;
    if (err_sync !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 4'd0 ||
        mem_wdata !== 8'hAA)
      $display("FAIL midsof_write: err=%b we=%b a=%0d d=%0h, required 1 1 0 aa",
               err_sync, mem_we, mem_addr, mem_wdata);
    else passes++;
    for (int k = 1; k < 15; k++)
      send(8'h40 + 8'(k), 1'b0, (k % 4) == 3);
    checks++;
    if (frame_done !== 1'b0 || done_count - d0 !== 0)
      $display("FAIL midsof_early_done: done=%b n=%0d, required 0 0",
               frame_done, done_count - d0);
    else passes++;
    send(8'h4F, 1'b0, 1'b1);
    checks++;
    if (frame_done !== 1'b1)
      $display("FAIL midsof_done: got %b, required 1", frame_done);
    else passes++;
    @(posedge clk); #1;
    exp_img[0] = 8'hAA;
    for (int k = 1; k < 16; k++) exp_img[k] = 8'h40 + 8'(k);
    check_img("midsof_ram");
    checks++;
    if (err_sync !== 1'b1)
      $display("FAIL midsof_sticky: got %b, required 1", err_sync);
    else passes++;
  endtask

  task automatic test_reset_mid_frame();
    int d0;
    clear_ram();
    d0 = done_count;
    do_start();
    checks++;
    if (err_sync !== 1'b0)
      $display("FAIL start_clears_err: got %b, required 0", err_sync);
    else passes++;
    for (int i = 0; i < 7; i++)
      send(8'h50 + 8'(i), i == 0, i == 1 || i == 5);
    checks++;
    if (mem_we !== 1'b1 || err_sync !== 1'b1)
      $display("FAIL mid_pending: we=%b err=%b, required 1 1",
               mem_we, err_sync);
    else passes++;
    reset = 1'b1;
    #1;
    checks++;
    if ({s_if.ready, mem_we, mem_addr, mem_wdata, busy,
         frame_done, err_sync} !== 17'd0)
      $display("FAIL mid_reset_outputs: got %b, required 0",
               {s_if.ready, mem_we, mem_addr, mem_wdata, busy,
                frame_done, err_sync});
    else passes++;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done_count - d0 !== 0 || busy !== 1'b0)
      $display("FAIL mid_no_done: n=%0d busy=%b, required 0 0",
               done_count - d0, busy);
    else passes++;
    clear_ram();
    do_start();
    send_frame(1'b0);
    checks++;
    if (frame_done !== 1'b1)
      $display("FAIL post_reset_done: got %b, required 1", frame_done);
    else passes++;
    @(posedge clk); #1;
    set_exp_ramp();
    check_img("post_reset_ram");
    checks++;
    if (done_count - d0 !== 1)
      $display("FAIL post_reset_count: n=%0d, required 1",
               done_count - d0);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_backpressure();
    test_pre_sof();
    test_early_eol();
    test_mid_sof();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sobel_frame_writer.md
# sobel_frame_writer

Stream sink at the output end of the Sobel filter path. It accepts filtered pixels over a valid/ready stream with start-of-frame and end-of-line markers, and tracks row and column position. It writes each pixel into a frame-buffer RAM through a synchronous write port, then pulses `frame_done` after the last pixel of the frame. It also checks stream framing and flags markers that arrive in the wrong place.

## Interface
Parameters:
- `IMAGE_WIDTH_E`, default 9: log2 of frame width.
- `IMAGE_HIGHT_E`, default 9: log2 of frame height.
- `IMAGE_WIDTH` = 2**`IMAGE_WIDTH_E`; `IMAGE_HIGHT` = 2**`IMAGE_HIGHT_E`.
- `BYTE_SIZE`, default 8: pixel width.

Ports:
- Clock and reset: reset reset, asynchronous, active-high; clock clk.
- `start`  in  1  one-cycle request to arm for a frame. Ignored unless in IDLE.
- `s_valid`  in  1  input pixel valid.
- `s_ready`  out  1  sink ready. A transfer occurs on `s_valid & s_ready`.
- `s_data`  in  `BYTE_SIZE`  filtered pixel.
- `s_sof`  in  1  marks the first pixel of a frame.
- `s_eol`  in  1  marks the last pixel of a line.
- `mem_we`  out  1  frame-buffer write enable.
- `mem_addr`  out  `IMAGE_WIDTH_E+IMAGE_HIGHT_E`  write address, equal to {row, col}.
- `mem_wdata`  out  `BYTE_SIZE`  write data.
- `busy`  out  1  high in WAIT_SOF and WRITE.
- `frame_done`  out  1  one-cycle pulse after the last pixel is written.
- `err_sync`  out  1  sticky framing error. Cleared by reset or by an accepted `start`.

## Operation
- States: IDLE, WAIT_SOF, WRITE, DONE. Encoding is 2 bits: 0, 1, 2, 3.
- IDLE:
  - `s_ready`=0.
  - `start` → WAIT_SOF; clear row, col and `err_sync`.
- WAIT_SOF:
  - `s_ready`=1.
  - A transfer without `s_sof` is discarded; no write occurs.
  - A transfer with `s_sof` writes at address 0, sets col=1 and moves to WRITE.
- WRITE:
  - `s_ready`=1. Each transfer writes at {row, col}.
  - Normal column step: if col < `IMAGE_WIDTH`-1, col increments.
  - End of line at col = `IMAGE_WIDTH`-1: col=0 and row increments.
  - `s_eol` at col ≠ `IMAGE_WIDTH`-1: set `err_sync`, write the pixel, then resync with col=0 and row+1.
  - Missing `s_eol` at col = `IMAGE_WIDTH`-1: set `err_sync`; the row still advances.
  - `s_sof` in WRITE: set `err_sync`, restart the frame, write this pixel at address 0, set col=1 and row=0.
  - Last pixel: a transfer at row = `IMAGE_HIGHT`-1 with the resulting row wrap (by position or by early `s_eol`) → DONE.
- DONE:
  - `s_ready`=0.
  - `frame_done`=1 for exactly this cycle.
  - Next state is IDLE unconditionally.
- Counter widths: col is `IMAGE_WIDTH_E` bits and row is `IMAGE_HIGHT_E` bits. Neither wraps inside WRITE; the end of frame is detected before row overflow.
- `start` outside IDLE is ignored and leaves `err_sync` unchanged.

## Timing
- Reset values: state=IDLE, `s_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `frame_done`=0, `err_sync`=0. Row and col are 0.
- `s_ready` is a decode of the registered state and has no combinational path from `s_valid`.
- Write latency: a transfer in cycle N produces `mem_we`=1, with its `mem_addr` and `mem_wdata`, in cycle N+1. `mem_we` is 0 in every other cycle.
- Throughput: one pixel per cycle while `s_valid` is held.
- `frame_done` is asserted in the cycle after the last-pixel transfer, the same cycle as its write. `busy` falls in that cycle.
- IDLE→WAIT_SOF takes one cycle after `start`, so `s_ready` rises the cycle after `start`.
- `err_sync` asserts the cycle after the offending transfer and holds.
- Reset asserted mid-frame: all outputs return to reset values immediately. The pending write is dropped and no `frame_done` is produced.

## Structure
- Shared package `sobel_pkg`:
  - `BYTE_SIZE`.
  - State encodings IDLE/WAIT_SOF/WRITE/DONE.
  - `IMAGE_WIDTH_E`/`IMAGE_HIGHT_E` defaults, shared with the filter and line-loader blocks.
- One natural sub-module, `pixel_pos_counter`:
  - Holds the row/col registers.
  - Handles inc, eol-resync and restart inputs.
  - Produces the `last_col` and `last_pixel` flags.
- The FSM, handshake and write register stay in the top module. The frame-buffer RAM is external; the bench supplies a behavioural model.

## Test plan
Parameters for all scenarios: `IMAGE_WIDTH_E`=2, `IMAGE_HIGHT_E`=2 (4x4 frame).
- Clean frame: `start`, then 16 back-to-back pixels 0x00..0x0F with `s_sof` on the first and `s_eol` every 4th → writes at addr 0..15 with data 0..15, one per cycle. `frame_done` pulses once, the cycle after pixel 16. `err_sync`=0.
- Backpressure gaps: the same frame with `s_valid` low on alternate cycles → an identical RAM image. `mem_we` is high only the cycle after each transfer.
- Pre-SOF garbage: 3 pixels without `s_sof` in WAIT_SOF, then a clean frame → no writes for the garbage. The RAM holds 0..15 and `err_sync`=0.
- Early EOL: `s_eol` on the pixel at row 1, col 1 → `err_sync`=1. The next pixel is written at addr 8 and the frame completes with `frame_done`.
- Mid-frame SOF: `s_sof` on the 6th pixel with data 0xAA → `err_sync`=1 and 0xAA is written at addr 0. `frame_done` comes after 16 further transfers counted from that pixel.
- Reset mid-frame: assert reset after 7 transfers → all outputs are 0 at once and no `frame_done`. After release, `start` plus a clean frame completes normally.
